io_interval_timer: RTL and testbench
====================================

Name: io_interval_timer

Overview:
- Responder-side I/O device on the KV10 I/O bus (io_dev/io_read/io_write/ack/PI), the far end of the cache→IOM interface.
- Provides a PDP-10-style programmable interval timer:
  - DATAO loads the interval; DATAI reads count and interval.
  - CONO sets the PI channel and control bits; CONI reads status.
- Raises a level PI request on the programmed channel when the interval expires.

Parameters:
- DEV, 7'o070, device code this block answers to.
- PRESCALE, 20, clk cycles per timer tick (1 µs at 20 MHz).
- CW, 18, counter/interval width (right half-word).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- io_dev  in  `DEVICE  addressed device code.
- io_cond  in  1  1 = CONO/CONI, 0 = DATAO/DATAI.
- io_write  in  1  write request (CONO/DATAO), held until ack seen.
- io_read  in  1  read request (CONI/DATAI), held until ack seen.
- io_write_data  in  `WORD  write data, bit 0 MSB, bit 35 LSB.
- io_read_data  out  `WORD  read data, valid while io_read_ack=1.
- io_write_ack  out  1  write acknowledge.
- io_read_ack  out  1  read acknowledge.
- io_pi  out  [1:7]  PI request lines.

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs 0.
  - pia=0, enable=0, done=0, count=0, interval=0, prescaler=0.
  - Any in-flight handshake is abandoned and its ack drops.
- Select: sel = (io_dev==DEV). Unselected requests get no ack, so the upstream nxd logic handles them.
- Handshake (full interlock):
  - Request sampled high with sel at edge N → ack registered high at edge N+1, held while the request stays high.
  - Ack drops the cycle after the request drops.
  - A new request is accepted only after ack has returned low.
- Write side effects: applied on the same edge that raises io_write_ack, exactly once per handshake.
- Read data: latched on the edge that raises io_read_ack, held stable while ack is high, zero otherwise.
- io_write and io_read both high: protocol violation; the write is serviced and the read is ignored.
- CONO bits:
  - 33-35 pia.
  - 32 enable.
  - 31 clear done.
  - 30 clear count and prescaler.
  - All other bits ignored.
- CONI: bits 33-35 pia, 32 enable, 31 done, all others 0.
- DATAO: interval ← bits 18-35; count and prescaler ← 0.
- DATAI: bits 0-17 interval, bits 18-35 count.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1; holds when enable=0.
  - tick = enable && prescaler==PRESCALE-1.
- On tick:
  - interval==0: count wraps modulo 2^CW and done is never set.
  - count+1==interval: count←0 and done←1.
  - Otherwise count←count+1.
- Simultaneous events:
  - DATAO or CONO clear-count in the same cycle as a tick: the write wins and the tick is lost.
  - CONO clear-done in the same cycle as an expiry: done ends 1 (set wins, so no interrupt is lost).
- PI: io_pi[k] = done && pia==k for k=1..7. pia=0 means no request. Level output, registered, 1-cycle latency after done or pia change.

Decomposition:
- Shared package/header (alongside constants.svh):
  - CONO/CONI bit-position constants (TMR_PIA, TMR_EN, TMR_CLR_DONE, TMR_CLR_CNT).
  - Device-code constant DEV_TIMER=7'o070.
  - Generic I/O responder handshake state encoding (IDLE, ACK), reused by future devices.
- One sub-module: io_prescaler (enable, clear → tick), parameterised by PRESCALE.

Test Plan:
- Reset with reset=0 for 2 cycles, then release → all outputs 0; CONI of DEV returns 0.
- CONO DEV data 0o000000_000015 (pia=5, enable), DATAO 0o000000_000003, PRESCALE=4 → done set 12 clks after DATAO ack; io_pi=7'b0000100 on the following cycle; DATAI reads 0o000003_000000 at expiry.
- CONO with bit 31 set while done=1 → io_pi returns to 0 one cycle later; count keeps running; next expiry re-raises io_pi[5].
- CONO clear-done timed on the exact expiry cycle → done remains 1 and io_pi[5] stays high.
- Hold io_write high 5 cycles with DATAO 0o000000_000010 → io_write_ack high from cycle 2 while held; interval written once; ack low 1 cycle after io_write drops.
- io_read with io_dev=7'o071 → no ack for 20 cycles. Assert reset=0 mid-handshake while ack is high → ack and io_pi drop at the next edge; all registers read 0 afterwards.

Source files
------------

// File: rtl/io_interval_timer_pkg.sv
// Shared constants for KV10 I/O responders: device codes, CONO/CONI bit positions,
// responder handshake states and PI decoding.
package io_interval_timer_pkg;

    localparam int unsigned WORD_W = 36;
    localparam int unsigned HALF_W = 18;

    localparam logic [6:0] DEV_TIMER = 7'o070;

    // Bit numbers are PDP-10 style: bit 0 is the MSB of the word.
    localparam int unsigned TMR_PIA      = 33;  // 3-bit field, bits 33-35
    localparam int unsigned TMR_EN       = 32;
    localparam int unsigned TMR_CLR_DONE = 31;
    localparam int unsigned TMR_CLR_CNT  = 30;

    typedef enum logic {
        StIdle,
        StAck
    } io_hs_e;

    function automatic logic [1:7] pi_decode(input logic done, input logic [2:0] pia);
        logic [1:7] req;
        req = '0;
        for (int k = 1; k <= 7; k++) begin
            req[k] = done && (pia == 3'(k));
        end
        return req;
    endfunction

endpackage

// File: rtl/io_interval_timer_prescaler.sv
// Free-running divider producing a one-cycle tick every PRESCALE enabled clocks.
module io_prescaler
    import io_interval_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_interval_timer.sv
// PDP-10 style programmable interval timer answering CONO/CONI/DATAO/DATAI on the KV10
// I/O bus with a full-interlock handshake and a level PI request on expiry.
module io_interval_timer
    import io_interval_timer_pkg::*;
#(
    parameter logic [6:0]  DEV      = DEV_TIMER,
    parameter int unsigned PRESCALE = 20,
    parameter int unsigned CW       = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  io_dev,
    input  logic        io_cond,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [0:35] io_write_data,
    output logic [0:35] io_read_data,
    output logic        io_write_ack,
    output logic        io_read_ack,
    output logic [1:7]  io_pi
);

    io_hs_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic [0:35]   rdata_q, rdata_d;
    logic [2:0]    pia_q, pia_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] interval_q, interval_d;
    logic [1:7]    pi_q, pi_d;

    logic          sel, do_write, do_read, cono, datao, clr_cnt;
    logic          tick, tick_eff, expire;
    logic [CW:0]   cnt_inc;
    logic [0:35]   coni_word, datai_word;

    io_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i    (clk),
        .rst_ni   (reset),
        .enable_i (en_q),
        .clear_i  (clr_cnt),
        .tick_o   (tick)
    );

    // Handshake: side effects happen only on the IDLE->ACK edge, so a held request
    // is serviced exactly once. A write wins over a simultaneous read.
    always_comb begin
        sel      = (io_dev == DEV);
        state_d  = state_q;
        wr_d     = wr_q;
        do_write = 1'b0;
        do_read  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel && io_write) begin
                    state_d  = StAck;
                    wr_d     = 1'b1;
                    do_write = 1'b1;
                end else if (sel && io_read) begin
                    state_d  = StAck;
                    wr_d     = 1'b0;
                    do_read  = 1'b1;
                end
            end
            StAck: begin
                if (wr_q ? !io_write : !io_read) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        coni_word                    = '0;
        coni_word[TMR_PIA +: 3]      = pia_q;
        coni_word[TMR_EN]            = en_q;
        coni_word[TMR_CLR_DONE]      = done_q;
        datai_word                   = {HALF_W'(interval_q), HALF_W'(count_q)};

        rdata_d = rdata_q;
        if (do_read) begin
            rdata_d = io_cond ? coni_word : datai_word;
        end else if (state_d == StIdle) begin
            rdata_d = '0;
        end
    end

    // A write that clears the count swallows a coincident tick; a coincident expiry
    // beats clear-done so no interrupt is lost.
    always_comb begin
        cono     = do_write && io_cond;
        datao    = do_write && !io_cond;
        clr_cnt  = datao || (cono && io_write_data[TMR_CLR_CNT]);
        tick_eff = tick && !clr_cnt;
        cnt_inc  = {1'b0, count_q} + (CW + 1)'(1);
        expire   = tick_eff && (interval_q != '0) && (cnt_inc == {1'b0, interval_q});

        count_d = count_q;
        if (tick_eff) begin
            count_d = expire ? '0 : cnt_inc[CW-1:0];
        end
        if (clr_cnt) begin
            count_d = '0;
        end

        interval_d = datao ? CW'(io_write_data[HALF_W:WORD_W-1]) : interval_q;
        pia_d      = cono ? io_write_data[TMR_PIA +: 3] : pia_q;
        en_d       = cono ? io_write_data[TMR_EN] : en_q;

        done_d = done_q;
        if (cono && io_write_data[TMR_CLR_DONE]) begin
            done_d = 1'b0;
        end
        if (expire) begin
            done_d = 1'b1;
        end

        pi_d = pi_decode(done_q, pia_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            pia_q      <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            interval_q <= '0;
            pi_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            pia_q      <= pia_d;
            en_q       <= en_d;
            done_q     <= done_d;
            count_q    <= count_d;
            interval_q <= interval_d;
            pi_q       <= pi_d;
        end
    end

    assign io_write_ack = (state_q == StAck) && wr_q;
    assign io_read_ack  = (state_q == StAck) && !wr_q;
    assign io_read_data = rdata_q;
    assign io_pi        = pi_q;

endmodule

// File: tb/tb_io_interval_timer.sv
// Self-checking bench for io_interval_timer: directed scenarios plus randomized
// interval/pia runs checked against an elapsed-time arithmetic model.
module tb_io_interval_timer;

    localparam logic [6:0] DEV = 7'o070;
    localparam int         P   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  io_dev;
    logic        io_cond;
    logic        io_write;
    logic        io_read;
    logic [0:35] io_write_data;
    logic [0:35] io_read_data;
    logic        io_write_ack;
    logic        io_read_ack;
    logic [1:7]  io_pi;

    int checks = 0;
    int errors = 0;

    io_interval_timer #(
        .DEV      (DEV),
        .PRESCALE (P),
        .CW       (18)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_dev        (io_dev),
        .io_cond       (io_cond),
        .io_write      (io_write),
        .io_read       (io_read),
        .io_write_data (io_write_data),
        .io_read_data  (io_read_data),
        .io_write_ack  (io_write_ack),
        .io_read_ack   (io_read_ack),
        .io_pi         (io_pi)
    );

    always #5 clk = ~clk;

    function automatic logic [1:7] pi_exp(input int pia, input bit done);
        logic [1:7] r;
        r = '0;
        if (done && pia > 0) r[pia] = 1'b1;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the ack has dropped.
    task automatic io_xfer(input logic cond, input logic wr, input logic [0:35] wdata,
                           output logic [0:35] rdata);
        int   waited;
        logic acked;
        io_dev = DEV; io_cond = cond; io_write = wr; io_read = !wr; io_write_data = wdata;
        acked = 1'b0;
        waited = 0;
        while (acked !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
            acked = wr ? io_write_ack : io_read_ack;
        end
        rdata = io_read_data;
        io_write = 1'b0;
        io_read = 1'b0;
        checks++;
        if (waited != 1 || acked !== 1'b1) begin
            errors++;
            $display("FAIL handshake_ack: waited %0d cycles acked=%b, required 1 cycle acked=1",
                     waited, acked);
        end
        @(negedge clk);
        checks++;
        if ({io_write_ack, io_read_ack} !== 2'b00 || io_read_data !== '0) begin
            errors++;
            $display("FAIL handshake_drop: acks=%b rdata=%o, required 00 and 0",
                     {io_write_ack, io_read_ack}, io_read_data);
        end
    endtask

    task automatic test_reset;
        logic [0:35] rd;
        reset = 1'b0; io_dev = '0; io_cond = 0; io_write = 0; io_read = 0; io_write_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({io_write_ack, io_read_ack, io_pi} !== '0 || io_read_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: acks=%b pi=%b rdata=%o, required all 0",
                     {io_write_ack, io_read_ack}, io_pi, io_read_data);
        end
        reset = 1'b1;
        io_xfer(1'b1, 1'b0, '0, rd);
        checks++;
        if (rd !== '0) begin
            errors++; $display("FAIL reset_coni: got %o, required 0", rd);
        end
        io_xfer(1'b0, 1'b0, '0, rd);
        checks++;
        if (rd !== '0) begin
            errors++; $display("FAIL reset_datai: got %o, required 0", rd);
        end
    endtask

    // Elapsed edges since the DATAO ack edge: 1 when io_xfer returns, +2 per later xfer.
    task automatic test_expiry;
        logic [0:35] rd;
        io_xfer(1'b1, 1'b1, 36'o15, rd);
        io_xfer(1'b0, 1'b1, 36'o3, rd);
        repeat (11) @(negedge clk);
        checks++;
        if (io_pi !== 7'b0000000) begin
            errors++; $display("FAIL expiry_pi_early: got %b, required 0000000", io_pi);
        end
        @(negedge clk);
        checks++;
        if (io_pi !== 7'b0000100) begin
            errors++; $display("FAIL expiry_pi: got %b, required 0000100", io_pi);
        end
        io_xfer(1'b0, 1'b0, '0, rd);
        checks++;
        if (rd !== 36'o000003_000000) begin
            errors++; $display("FAIL expiry_datai: got %o, required 000003000000", rd);
        end
        io_xfer(1'b1, 1'b0, '0, rd);
        checks++;
        if (rd !== 36'o35) begin
            errors++; $display("FAIL expiry_coni: got %o, required 35", rd);
        end
    endtask

    task automatic test_clear_done;
        logic [0:35] rd;
        io_xfer(1'b1, 1'b1, 36'o35, rd);
        checks++;
        if (io_pi !== 7'b0000000) begin
            errors++; $display("FAIL clear_done_pi: got %b, required 0000000", io_pi);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (io_pi !== 7'b0000000) begin
            errors++; $display("FAIL rerun_pi_early: got %b, required 0000000", io_pi);
        end
        @(negedge clk);
        checks++;
        if (io_pi !== 7'b0000100) begin
            errors++; $display("FAIL rerun_pi: got %b, required 0000100", io_pi);
        end
    endtask

    task automatic test_clear_on_expiry;
        logic [0:35] rd;
        repeat (10) @(negedge clk);
        io_xfer(1'b1, 1'b1, 36'o35, rd);
        checks++;
        if (io_pi !== 7'b0000100) begin
            errors++; $display("FAIL set_wins_pi: got %b, required 0000100", io_pi);
        end
        io_xfer(1'b1, 1'b0, '0, rd);
        checks++;
        if (rd !== 36'o35) begin
            errors++; $display("FAIL set_wins_coni: got %o, required 35", rd);
        end
    endtask

    task automatic test_hold_write;
        logic [0:35] rd;
        logic        held_ok;
        io_dev = DEV; io_cond = 1'b0; io_write_data = 36'o10; io_write = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (io_write_ack !== 1'b1) held_ok = 1'b0;
        end
        io_write = 1'b0;
        checks++;
        if (held_ok !== 1'b1) begin
            errors++; $display("FAIL hold_ack: ack dropped while held, required held high");
        end
        @(negedge clk);
        checks++;
        if (io_write_ack !== 1'b0) begin
            errors++; $display("FAIL hold_ack_drop: got %b, required 0", io_write_ack);
        end
        io_xfer(1'b0, 1'b0, '0, rd);
        checks++;
        if (rd !== 36'o000010_000001) begin
            errors++; $display("FAIL hold_once_datai: got %o, required 000010000001", rd);
        end
    endtask

    task automatic test_unselected;
        logic seen;
        io_dev = 7'o071; io_cond = 1'b1; io_read = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (io_read_ack !== 1'b0 || io_write_ack !== 1'b0) seen = 1'b1;
        end
        io_read = 1'b0;
        @(negedge clk);
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL unselected_ack: got ack, required none");
        end
    endtask

    task automatic test_reset_mid;
        logic [0:35] rd;
        checks++;
        if (io_pi !== 7'b0000100) begin
            errors++; $display("FAIL mid_pre_pi: got %b, required 0000100", io_pi);
        end
        io_dev = DEV; io_cond = 1'b1; io_read = 1'b1;
        @(negedge clk);
        checks++;
        if (io_read_ack !== 1'b1) begin
            errors++; $display("FAIL mid_pre_ack: got %b, required 1", io_read_ack);
        end
        reset = 1'b0;
        io_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({io_write_ack, io_read_ack, io_pi} !== '0 || io_read_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: acks=%b pi=%b rdata=%o, required all 0",
                     {io_write_ack, io_read_ack}, io_pi, io_read_data);
        end
        reset = 1'b1;
        io_xfer(1'b1, 1'b0, '0, rd);
        checks++;
        if (rd !== '0) begin
            errors++; $display("FAIL mid_coni: got %o, required 0", rd);
        end
        io_xfer(1'b0, 1'b0, '0, rd);
        checks++;
        if (rd !== '0) begin
            errors++; $display("FAIL mid_datai: got %o, required 0", rd);
        end
    endtask

    // Model: with continuous enable since DATAO, ticks = e/P, count = ticks % I,
    // done = ticks >= I, and io_pi lags done by one edge.
    task automatic test_random;
        logic [0:35] rd, want;
        int iv, pia, w, e;
        for (int it = 0; it < 8; it++) begin
            iv  = $urandom_range(1, 6);
            pia = $urandom_range(1, 7);
            io_xfer(1'b1, 1'b1, 36'o70 | 36'(pia), rd);
            io_xfer(1'b0, 1'b1, 36'(iv), rd);
            e = 1;
            w = $urandom_range(0, 40);
            repeat (w) @(negedge clk);
            e += w;
            checks++;
            if (io_pi !== pi_exp(pia, ((e - 1) / P) >= iv)) begin
                errors++;
                $display("FAIL rand_pi: it %0d got %b, required %b", it, io_pi,
                         pi_exp(pia, ((e - 1) / P) >= iv));
            end
            want = 36'o10 | 36'(pia) | (((e / P) >= iv) ? 36'o20 : 36'o0);
            io_xfer(1'b1, 1'b0, '0, rd);
            e += 2;
            checks++;
            if (rd !== want) begin
                errors++; $display("FAIL rand_coni: it %0d got %o, required %o", it, rd, want);
            end
            want = {18'(iv), 18'((e / P) % iv)};
            io_xfer(1'b0, 1'b0, '0, rd);
            checks++;
            if (rd !== want) begin
                errors++; $display("FAIL rand_datai: it %0d got %o, required %o", it, rd, want);
            end
        end
    endtask

    initial begin
        test_reset;
        test_expiry;
        test_clear_done;
        test_clear_on_expiry;
        test_hold_write;
        test_unselected;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
